// File: rtl/mp_addsub_serial.sv
// Word-serial multi-precision adder/subtractor: one WORD-bit limb per clock, LSB first,
// with accumulate (A = current result) and an idle-time 1-bit right shift of the result.
module mp_addsub_serial #(
    parameter int WIDTH = 514,
    parameter int WORD  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic             accumulate,
    input  logic             shift,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int RW = WIDTH + 1;
    localparam int NW = (RW + WORD - 1) / WORD;
    localparam int PW = NW * WORD;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [PW-1:0]   b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic            cin_q, cin_d;
    logic            sub_q, sub_d;
    logic [CW-1:0]   limb_q, limb_d;
    logic [RW-1:0]   result_q, result_d;
    logic            carry_q, carry_d;

    logic [WORD:0]   limb_sum;
    logic [PW:0]     full_sum;

    // Operands shift right one limb per RUN cycle while finished limbs enter acc from the top,
    // so after NW cycles acc holds the padded sum and full_sum's top bit is the final carry-out.
    always_comb begin
        limb_sum = {1'b0, a_q[WORD-1:0]} + {1'b0, b_q[WORD-1:0]} + (WORD+1)'(cin_q);
        full_sum = {limb_sum, acc_q[PW-1:WORD]};

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cin_d    = cin_q;
        sub_d    = sub_q;
        limb_d   = limb_q;
        result_d = result_q;
        carry_d  = carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = accumulate ? PW'(result_q) : PW'(in_a);
                    b_d     = subtract ? ~PW'(in_b) : PW'(in_b);
                    cin_d   = subtract;
                    sub_d   = subtract;
                    limb_d  = '0;
                    state_d = RUN;
                end else if (shift) begin
                    result_d = {1'b0, result_q[RW-1:1]};
                end
            end
            RUN: begin
                a_d    = a_q >> WORD;
                b_d    = b_q >> WORD;
                acc_d  = full_sum[PW-1:0];
                cin_d  = full_sum[PW];
                limb_d = limb_q + CW'(1);
                if (limb_q == CW'(NW - 1)) begin
                    // Subtraction carry is the no-borrow flag of the padded difference.
                    result_d = full_sum[RW-1:0];
                    carry_d  = sub_q ? full_sum[PW] : full_sum[RW];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            limb_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cin_q    <= cin_d;
            sub_q    <= sub_d;
            limb_q   <= limb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_mp_addsub_serial.sv
// Bench for mp_addsub_serial: WORD=64 and WORD=32 instances driven in lockstep and checked
// against a plain-arithmetic model of A+B / A-B mod 2^(WIDTH+1) plus latency/handshake counts.
module tb_mp_addsub_serial;

    localparam int WIDTH = 514;
    localparam int RW    = WIDTH + 1;
    localparam int NW64  = (RW + 63) / 64;
    localparam int NW32  = (RW + 31) / 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             subtract;
    logic             accumulate;
    logic             shift;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [RW-1:0]    r64, r32;
    logic             c64, c32, busy64, busy32, done64, done32;

    int checks = 0;
    int fails  = 0;

    logic [RW-1:0] model_result;
    logic          model_carry;

    mp_addsub_serial #(.WIDTH(WIDTH), .WORD(64)) dut64 (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .accumulate(accumulate), .shift(shift), .in_a(in_a), .in_b(in_b),
        .result(r64), .carry(c64), .busy(busy64), .done(done64)
    );

    mp_addsub_serial #(.WIDTH(WIDTH), .WORD(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .accumulate(accumulate), .shift(shift), .in_a(in_a), .in_b(in_b),
        .result(r32), .carry(c32), .busy(busy32), .done(done32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW:0] obs, input logic [RW:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " result64"}, {1'b0, r64}, {1'b0, model_result});
        check({tag, " carry64"}, {{RW{1'b0}}, c64}, {{RW{1'b0}}, model_carry});
        check({tag, " result32"}, {1'b0, r32}, {1'b0, model_result});
        check({tag, " carry32"}, {{RW{1'b0}}, c32}, {{RW{1'b0}}, model_carry});
    endtask

    // Reference: straight modular arithmetic on (WIDTH+1)-bit values.
    task automatic model_op(input logic sub, input logic acc, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        logic [RW-1:0] aext;
        logic [RW:0]   t;
        aext = acc ? model_result : RW'(a);
        if (sub) begin
            model_result = aext - RW'(b);
            model_carry  = (aext >= RW'(b));
        end else begin
            t            = {1'b0, aext} + (RW+1)'(b);
            model_result = t[RW-1:0];
            model_carry  = t[RW];
        end
    endtask

    task automatic run_op(input string tag, input logic sub, input logic acc,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold_start, input bit shift_mid, input bit shift_start);
        logic [RW-1:0] prev;
        int lat64, lat32, dn64, dn32, bz64, bz32;
        prev = model_result;
        model_op(sub, acc, a, b);
        @(negedge clk);
        subtract = sub; accumulate = acc; in_a = a; in_b = b;
        start = 1'b1; shift = shift_start;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        shift = 1'b0;
        lat64 = 0; lat32 = 0; dn64 = 0; dn32 = 0;
        bz64 = int'(busy64); bz32 = int'(busy32);
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge clk); #1;
            if (done64) begin dn64++; lat64 = cyc; end
            if (done32) begin dn32++; lat32 = cyc; end
            bz64 += int'(busy64);
            bz32 += int'(busy32);
            if (cyc == 3) begin
                check({tag, " hold64"}, {1'b0, r64}, {1'b0, prev});
                check({tag, " hold32"}, {1'b0, r32}, {1'b0, prev});
                if (shift_mid) shift = 1'b1;
            end
            if (cyc == 4) shift = 1'b0;
            if (cyc == 8) start = 1'b0;
        end
        check({tag, " latency64"}, (RW+1)'(lat64), (RW+1)'(NW64));
        check({tag, " latency32"}, (RW+1)'(lat32), (RW+1)'(NW32));
        check({tag, " donecount64"}, (RW+1)'(dn64), (RW+1)'(1));
        check({tag, " donecount32"}, (RW+1)'(dn32), (RW+1)'(1));
        check({tag, " busycycles64"}, (RW+1)'(bz64), (RW+1)'(NW64 + 1));
        check({tag, " busycycles32"}, (RW+1)'(bz32), (RW+1)'(NW32 + 1));
        check_outputs(tag);
    endtask

    task automatic do_shift(input string tag);
        @(negedge clk);
        shift = 1'b1;
        @(posedge clk); #1;
        shift = 1'b0;
        model_result = model_result >> 1;
        check_outputs(tag);
        @(posedge clk); #1;
        check_outputs({tag, " once"});
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < 17; i++) v = (v << 32) | WIDTH'($urandom());
        return v;
    endfunction

    initial begin
        logic [WIDTH-1:0] all_ones;
        logic [WIDTH-1:0] ra, rb;
        int               dn;
        all_ones = '1;
        reset = 1'b1; start = 1'b0; subtract = 1'b0; accumulate = 1'b0; shift = 1'b0;
        in_a = '0; in_b = '0;
        model_result = '0; model_carry = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset busy64", (RW+1)'(busy64), '0);
        check("reset busy32", (RW+1)'(busy32), '0);
        check("reset done64", (RW+1)'(done64), '0);
        check("reset done32", (RW+1)'(done32), '0);
        @(negedge clk);
        reset = 1'b0;

        run_op("1+1", 1'b0, 1'b0, WIDTH'(1), WIDTH'(1), 1'b0, 1'b0, 1'b0);
        run_op("1-1", 1'b1, 1'b0, WIDTH'(1), WIDTH'(1), 1'b0, 1'b0, 1'b0);
        run_op("1-2", 1'b1, 1'b0, WIDTH'(1), WIDTH'(2), 1'b0, 1'b0, 1'b0);
        check("1-2 allones", {1'b0, r64}, {1'b0, {RW{1'b1}}});
        run_op("chain", 1'b0, 1'b0, all_ones, WIDTH'(1), 1'b0, 1'b0, 1'b0);
        do_shift("shift");
        run_op("chain midshift", 1'b0, 1'b0, all_ones, WIDTH'(1), 1'b0, 1'b1, 1'b0);
        run_op("acc1", 1'b0, 1'b1, '0, all_ones, 1'b0, 1'b0, 1'b0);
        run_op("acc2", 1'b0, 1'b1, '0, WIDTH'(1), 1'b0, 1'b0, 1'b0);

        // Abort in the 4th RUN cycle, then confirm no done pulse appears.
        @(negedge clk);
        subtract = 1'b0; accumulate = 1'b0; in_a = WIDTH'(3); in_b = WIDTH'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_result = '0; model_carry = 1'b0;
        check_outputs("abort");
        check("abort busy64", (RW+1)'(busy64), '0);
        check("abort busy32", (RW+1)'(busy32), '0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dn += int'(done64) + int'(done32);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            dn += int'(done64) + int'(done32);
        end
        check("abort nodone", (RW+1)'(dn), '0);

        run_op("5+7", 1'b0, 1'b0, WIDTH'(5), WIDTH'(7), 1'b0, 1'b0, 1'b0);
        check("5+7 twelve", {1'b0, r64}, (RW+1)'(12));
        run_op("held start", 1'b0, 1'b1, '0, WIDTH'(100), 1'b1, 1'b0, 1'b0);
        run_op("start+shift", 1'b1, 1'b1, '0, WIDTH'(9), 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = rand_word();
            rb = rand_word();
            if (i == 3) rb = ra;
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ra, rb, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
